// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | writeback_arbiter_if: execute-unit results into writeback, plus   |
// | the register-file write port and Issue back-pressure flags.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface writeback_arbiter_if;
  logic [4:0]  x_wb_regdest;
  logic        x_wb_writereg;
  logic [31:0] x_wb_wbvalue;
  logic [4:0]  y_wb_regdest;
  logic        y_wb_writereg;
  logic [31:0] y_wb_wbvalue;
  logic [4:0]  m_wb_regdest;
  logic        m_wb_writereg;
  logic [31:0] m_wb_wbvalue;
  logic [4:0]  wb_rf_regdest;
  logic        wb_rf_writereg;
  logic [31:0] wb_rf_wbvalue;
  logic        wb_is_stall;
  logic        wb_overflow;

  modport master (
    output x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    output y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    output m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
    input  wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue,
    input  wb_is_stall, wb_overflow
  );

  modport slave (
    input  x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    input  y_wb_regdest, y_wb_writereg, y_wb_wbvalue,
    input  m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
    output wb_rf_regdest, wb_rf_writereg, wb_rf_wbvalue,
    output wb_is_stall, wb_overflow
  );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | writeback_arbiter: per-unit result FIFOs (X, Y, M) drained        |
// | round-robin into the single register-file write port.             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  wire logic       clock,
  input  wire logic       reset,
  writeback_arbiter_if.slave wb
);

  localparam int c_NSRC = 3;
  localparam int c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW   = c_AW + 1;
  localparam int c_EW   = 37;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_HIGH = c_CW'(DEPTH - 1);

  function automatic logic [1:0] f_mod3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  logic [c_NSRC-1:0] w_push_req;
  logic [c_EW-1:0]   w_push_data [c_NSRC];
  logic [c_EW-1:0]   w_head      [c_NSRC];
  logic [c_NSRC-1:0] w_nonempty;
  logic [c_NSRC-1:0] w_high;
  logic [c_NSRC-1:0] w_drop;
  logic [c_NSRC-1:0] w_pop;
  logic              w_grant_vld;
  logic [1:0]        w_grant;
  logic [1:0]        w_idx;
  logic [c_EW-1:0]   w_sel_head;

  logic [1:0]        r_rr_ptr;
  logic [4:0]        r_rf_regdest;
  logic              r_rf_writereg;
  logic [31:0]       r_rf_wbvalue;
  logic              r_overflow;

  // Writes to r0 are never queued and never count as an overflow.
  always_comb begin
    w_push_req[0]  = wb.x_wb_writereg && (wb.x_wb_regdest != 5'd0);
    w_push_req[1]  = wb.y_wb_writereg && (wb.y_wb_regdest != 5'd0);
    w_push_req[2]  = wb.m_wb_writereg && (wb.m_wb_regdest != 5'd0);
    w_push_data[0] = {wb.x_wb_regdest, wb.x_wb_wbvalue};
    w_push_data[1] = {wb.y_wb_regdest, wb.y_wb_wbvalue};
    w_push_data[2] = {wb.m_wb_regdest, wb.m_wb_wbvalue};
  end

  for (genvar s = 0; s < c_NSRC; s++) begin : g_src
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_push;

    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign w_push        = w_push_req[s] && ((r_count != c_FULL) || w_pop[s]);
    assign w_drop[s]     = w_push_req[s] && (r_count == c_FULL) && !w_pop[s];
    assign w_nonempty[s] = (r_count != '0);
    assign w_high[s]     = (r_count >= c_HIGH);
    assign w_head[s]     = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)   r_wr_ptr <= r_wr_ptr + c_AW'(1);
        if (w_pop[s]) r_rd_ptr <= r_rd_ptr + c_AW'(1);
        case ({w_push, w_pop[s]})
          2'b10:   r_count <= r_count + c_CW'(1);
          2'b01:   r_count <= r_count - c_CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_data[s];
    end
  end

  // Scan from lowest priority up so the first non-empty source after rr_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 2'd0;
    w_idx       = 2'd0;
    for (int k = c_NSRC - 1; k >= 0; k--) begin
      w_idx = f_mod3({1'b0, r_rr_ptr} + 3'(k));
      if (w_nonempty[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  always_comb begin
    w_pop      = '0;
    w_sel_head = w_head[0];
    if (w_grant_vld) begin
      case (w_grant)
        2'd1:    begin w_pop = 3'b010; w_sel_head = w_head[1]; end
        2'd2:    begin w_pop = 3'b100; w_sel_head = w_head[2]; end
        default: begin w_pop = 3'b001; w_sel_head = w_head[0]; end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr      <= 2'd0;
      r_rf_regdest  <= 5'd0;
      r_rf_writereg <= 1'b0;
      r_rf_wbvalue  <= 32'd0;
      r_overflow    <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (|w_drop);
      if (w_grant_vld) begin
        r_rf_writereg <= 1'b1;
        r_rf_regdest  <= w_sel_head[36:32];
        r_rf_wbvalue  <= w_sel_head[31:0];
        r_rr_ptr      <= f_mod3({1'b0, w_grant} + 3'd1);
      end else begin
        r_rf_writereg <= 1'b0;
      end
    end
  end

  assign wb.wb_rf_regdest  = r_rf_regdest;
  assign wb.wb_rf_writereg = r_rf_writereg;
  assign wb.wb_rf_wbvalue  = r_rf_wbvalue;
  assign wb.wb_overflow    = r_overflow;
  assign wb.wb_is_stall    = |w_high;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_writeback_arbiter: directed vectors for the writeback arbiter. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_writeback_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  writeback_arbiter_if wb ();

  writeback_arbiter #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb.x_wb_writereg = 1'b0; wb.x_wb_regdest = 5'd0; wb.x_wb_wbvalue = 32'd0;
    wb.y_wb_writereg = 1'b0; wb.y_wb_regdest = 5'd0; wb.y_wb_wbvalue = 32'd0;
    wb.m_wb_writereg = 1'b0; wb.m_wb_regdest = 5'd0; wb.m_wb_wbvalue = 32'd0;
  endtask

  task automatic put(input int src, input logic [4:0] d, input logic [31:0] v);
    case (src)
      0: begin wb.x_wb_writereg = 1'b1; wb.x_wb_regdest = d; wb.x_wb_wbvalue = v; end
      1: begin wb.y_wb_writereg = 1'b1; wb.y_wb_regdest = d; wb.y_wb_wbvalue = v; end
      default: begin wb.m_wb_writereg = 1'b1; wb.m_wb_regdest = d; wb.m_wb_wbvalue = v; end
    endcase
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] d, input logic [31:0] v);
    check({tag, ".we"},   64'(wb.wb_rf_writereg), 64'd1);
    check({tag, ".dest"}, 64'(wb.wb_rf_regdest),  64'(d));
    check({tag, ".val"},  64'(wb.wb_rf_wbvalue),  64'(v));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #2;
    check("rst.we",    64'(wb.wb_rf_writereg), 64'd0);
    check("rst.dest",  64'(wb.wb_rf_regdest),  64'd0);
    check("rst.val",   64'(wb.wb_rf_wbvalue),  64'd0);
    check("rst.stall", 64'(wb.wb_is_stall),    64'd0);
    check("rst.ovf",   64'(wb.wb_overflow),    64'd0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    idle();
    #1;

    // T1: single Y result, two-edge latency.
    do_reset();
    put(1, 5'd5, 32'h30);
    tick();
    idle();
    check("t1.e1.we", 64'(wb.wb_rf_writereg), 64'd0);
    tick();
    expect_wr("t1.e2", 5'd5, 32'h30);
    tick();
    check("t1.e3.we",   64'(wb.wb_rf_writereg), 64'd0);
    check("t1.e3.hold", 64'(wb.wb_rf_regdest),  64'd5);

    // T2: simultaneous X/Y/M drain in source order, pointer returns to X.
    do_reset();
    put(0, 5'd1, 32'h11); put(1, 5'd2, 32'h22); put(2, 5'd3, 32'h33);
    tick();
    idle();
    check("t2.e1.we", 64'(wb.wb_rf_writereg), 64'd0);
    tick(); expect_wr("t2.r1", 5'd1, 32'h11);
    tick(); expect_wr("t2.r2", 5'd2, 32'h22);
    tick(); expect_wr("t2.r3", 5'd3, 32'h33);
    tick();
    check("t2.idle.we",  64'(wb.wb_rf_writereg), 64'd0);
    check("t2.idle.val", 64'(wb.wb_rf_wbvalue),  64'h33);
    put(0, 5'd4, 32'h44); put(1, 5'd6, 32'h66);
    tick();
    idle();
    tick(); expect_wr("t2.rr.x", 5'd4, 32'h44);
    tick(); expect_wr("t2.rr.y", 5'd6, 32'h66);

    // T3: X and Y every cycle; writes alternate, Y overfills on edge 8.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      put(0, 5'd1, 32'h100 + 32'(e - 1));
      put(1, 5'd2, 32'h200 + 32'(e - 1));
      tick();
      if (e >= 2)
        expect_wr($sformatf("t3.e%0d", e), 5'((e - 2) % 2 + 1),
                  32'(((e - 2) % 2 + 1) * 256 + (e - 2) / 2));
      if (e == 3) check("t3.stall.e3", 64'(wb.wb_is_stall), 64'd0);
      if (e == 4) check("t3.stall.e4", 64'(wb.wb_is_stall), 64'd1);
      if (e == 7) check("t3.ovf.e7",   64'(wb.wb_overflow), 64'd0);
      if (e == 8) check("t3.ovf.e8",   64'(wb.wb_overflow), 64'd1);
    end
    idle();

    // T4: all three sources for 6 cycles; M's 6th result is dropped, rest drain in order.
    do_reset();
    for (int e = 1; e <= 19; e++) begin
      idle();
      if (e <= 6) begin
        put(0, 5'd1, 32'h100 + 32'(e - 1));
        put(1, 5'd2, 32'h200 + 32'(e - 1));
        put(2, 5'd3, 32'h300 + 32'(e - 1));
      end
      tick();
      if (e >= 2 && e <= 18)
        expect_wr($sformatf("t4.e%0d", e), 5'((e - 2) % 3 + 1),
                  32'(((e - 2) % 3 + 1) * 256 + (e - 2) / 3));
      else
        check($sformatf("t4.e%0d.we", e), 64'(wb.wb_rf_writereg), 64'd0);
      if (e == 2) check("t4.stall.e2", 64'(wb.wb_is_stall), 64'd0);
      if (e == 3) check("t4.stall.e3", 64'(wb.wb_is_stall), 64'd1);
      if (e == 5) check("t4.ovf.e5",   64'(wb.wb_overflow), 64'd0);
      if (e == 6) check("t4.ovf.e6",   64'(wb.wb_overflow), 64'd1);
    end
    check("t4.ovf.sticky", 64'(wb.wb_overflow), 64'd1);
    check("t4.stall.end",  64'(wb.wb_is_stall), 64'd0);

    // T5: write to r0 is discarded without overflow.
    do_reset();
    put(0, 5'd0, 32'hDEAD);
    tick();
    idle();
    tick();
    check("t5.we",  64'(wb.wb_rf_writereg), 64'd0);
    check("t5.ovf", 64'(wb.wb_overflow),    64'd0);
    tick();
    check("t5.we2", 64'(wb.wb_rf_writereg), 64'd0);

    // T6: async reset mid-drain discards queued entries.
    do_reset();
    for (int e = 1; e <= 2; e++) begin
      put(0, 5'd1, 32'h500 + 32'(e));
      put(1, 5'd2, 32'h600 + 32'(e));
      put(2, 5'd3, 32'h700 + 32'(e));
      tick();
    end
    idle();
    tick();
    expect_wr("t6.pre", 5'd2, 32'h601);
    #2 reset = 1'b0;
    #1;
    check("t6.async.we",   64'(wb.wb_rf_writereg), 64'd0);
    check("t6.async.dest", 64'(wb.wb_rf_regdest),  64'd0);
    check("t6.async.val",  64'(wb.wb_rf_wbvalue),  64'd0);
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("t6.post%0d.we", e), 64'(wb.wb_rf_writereg), 64'd0);
    end
    check("t6.stall", 64'(wb.wb_is_stall), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
